// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
// Holds the FSM states, forwarding encodings, stage-control bundle and default memory timeout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD     = 6'b0000_00;
  localparam ctrl_t CTRL_RESET    = 6'b0000_11;
  localparam ctrl_t CTRL_RUN      = 6'b1111_00;
  localparam ctrl_t CTRL_BRANCH   = 6'b1111_11;
  localparam ctrl_t CTRL_LOAD_USE = 6'b0011_01;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: stage register fields in, stage enables and selects out.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if;

  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [2:0]  ex_rs1;
  logic [2:0]  ex_rs2;
  logic [2:0]  ex_regwradd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [2:0]  mem_regwradd;
  logic        mem_regwrite;
  logic [2:0]  wb_regwradd;
  logic        wb_regwrite;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ack;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_err;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_regwradd, ex_regwrite, ex_memread,
    output mem_regwradd, mem_regwrite, wb_regwradd, wb_regwrite,
    output branch_taken, mem_req, mem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
    input  fwd_a, fwd_b, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_regwradd, ex_regwrite, ex_memread,
    input  mem_regwradd, mem_regwrite, wb_regwradd, wb_regwrite,
    input  branch_taken, mem_req, mem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
    output fwd_a, fwd_b, mem_err, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational, zero-cycle.
// The nearer producer (EX/MEM) wins over MEM/WB; r0 is an ordinary register.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [2:0] ex_rs1,
  input  logic [2:0] ex_rs2,
  input  logic [2:0] mem_regwradd,
  input  logic       mem_regwrite,
  input  logic [2:0] wb_regwradd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = (mem_regwrite && (mem_regwradd == ex_rs1)) ? FWD_MEM :
                 (wb_regwrite  && (wb_regwradd  == ex_rs1)) ? FWD_WB  : FWD_RF;

  assign fwd_b = (mem_regwrite && (mem_regwradd == ex_rs2)) ? FWD_MEM :
                 (wb_regwrite  && (wb_regwradd  == ex_rs2)) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flush/bubble and forwarding are zero-cycle; memory freeze with timeout to sticky ERR.
// Optional saturating perf counters built only with HAZ_PERF_CNT_EN defined (otherwise tied to zero).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk1,
  input  logic rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT8 = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] wait_nxt;
  logic       freeze;
  logic       hit_rs1, hit_rs2;
  logic       load_use;
  ctrl_t      ctrl;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign freeze   = bus.mem_req && !bus.mem_ack;
  assign hit_rs1  = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_regwradd);
  assign hit_rs2  = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_regwradd);
  assign load_use = bus.ex_memread && bus.ex_regwrite && (hit_rs1 || hit_rs2);
  assign wait_nxt = wait_q + 8'd1;

  fwd_unit u_fwd (
    .ex_rs1       (bus.ex_rs1),
    .ex_rs2       (bus.ex_rs2),
    .mem_regwradd (bus.mem_regwradd),
    .mem_regwrite (bus.mem_regwrite),
    .wb_regwradd  (bus.wb_regwradd),
    .wb_regwrite  (bus.wb_regwrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  // Priority: rst, ERR, freeze, branch, load-use, normal.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (state_q == ST_ERR) begin
      ctrl = CTRL_HOLD;
    end else if (freeze) begin
      ctrl = CTRL_HOLD;
    end else if (bus.branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          wait_d  = 8'd1;
          state_d = (TIMEOUT8 <= 8'd1) ? ST_ERR : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          wait_d  = wait_nxt;
          state_d = (wait_nxt >= TIMEOUT8) ? ST_ERR : ST_MEM_WAIT;
        end else begin
          // Ack (or a withdrawn request) releases the freeze this cycle.
          wait_d  = 8'd0;
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_bubble = ctrl.idex_bubble;
  assign bus.fwd_a       = rst ? FWD_RF : fwd_a_raw;
  assign bus.fwd_b       = rst ? FWD_RF : fwd_b_raw;
  assign bus.mem_err     = (state_q == ST_ERR);

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // A load-use masked by a branch is not a stall; a frozen branch is not yet a flush.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (state_q != ST_ERR) begin
      if (freeze || (load_use && !bus.branch_taken))
        stall_cycles_d = sat_inc(stall_cycles_q);
      if (!freeze && bus.branch_taken)
        flush_count_d = sat_inc(flush_count_q);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_cycles_q <= 16'h0000;
      flush_count_q  <= 16'h0000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`else
  assign bus.stall_cycles = 16'h0000;
  assign bus.flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=15).
// Counter expectations follow HAZ_PERF_CNT_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk1;
  logic rst;
  int   errors;
  int   checks;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] ctrl_vec();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.ifid_flush, bus.idex_bubble};
  endfunction

  task automatic clear_inputs();
    bus.id_rs1 = 3'd0;       bus.id_rs2 = 3'd0;
    bus.id_use_rs1 = 1'b0;   bus.id_use_rs2 = 1'b0;
    bus.ex_rs1 = 3'd0;       bus.ex_rs2 = 3'd0;
    bus.ex_regwradd = 3'd0;  bus.ex_regwrite = 1'b0;  bus.ex_memread = 1'b0;
    bus.mem_regwradd = 3'd0; bus.mem_regwrite = 1'b0;
    bus.wb_regwradd = 3'd0;  bus.wb_regwrite = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0;      bus.mem_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.mem_regwrite = 1'b1; bus.mem_regwradd = 3'd1; bus.ex_rs1 = 3'd1; bus.ex_rs2 = 3'd1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b000011) begin
      errors++; $display("FAIL rst_ctrl got=%b exp=%b", ctrl_vec(), 6'b000011);
    end
    checks++;
    if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
      errors++; $display("FAIL rst_fwd got=%b/%b exp=00/00", bus.fwd_a, bus.fwd_b);
    end
    step();
    checks++;
    if (dut.state_q !== ST_RUN || bus.mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_state got=%0d err=%b exp=RUN err=0", dut.state_q, bus.mem_err);
    end
    checks++;
    if (bus.stall_cycles !== 16'h0 || bus.flush_count !== 16'h0) begin
      errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", bus.stall_cycles, bus.flush_count);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111100) begin
      errors++; $display("FAIL post_rst_ctrl got=%b exp=%b", ctrl_vec(), 6'b111100);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] exp_stall;
    do_reset();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_regwradd = 3'd3;
    bus.id_rs1 = 3'd4; bus.id_use_rs1 = 1'b1;
    bus.id_rs2 = 3'd3; bus.id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111100) begin
      errors++; $display("FAIL lu_unused_src got=%b exp=%b", ctrl_vec(), 6'b111100);
    end
    bus.id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b001101) begin
      errors++; $display("FAIL lu_stall got=%b exp=%b", ctrl_vec(), 6'b001101);
    end
    step();
    // bubble now in EX, load in MEM, consumer still in ID
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_regwradd = 3'd0;
    bus.mem_regwrite = 1'b1; bus.mem_regwradd = 3'd3;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111100) begin
      errors++; $display("FAIL lu_one_cycle got=%b exp=%b", ctrl_vec(), 6'b111100);
    end
    step();
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_rs1 = 3'd4; bus.ex_rs2 = 3'd3;
    bus.mem_regwrite = 1'b0; bus.mem_regwradd = 3'd0;
    bus.wb_regwrite = 1'b1; bus.wb_regwradd = 3'd3;
    #1;
    checks++;
    if (bus.fwd_b !== 2'b10 || bus.fwd_a !== 2'b00) begin
      errors++; $display("FAIL lu_fwd got=%b/%b exp=00/10", bus.fwd_a, bus.fwd_b);
    end
    exp_stall = PERF ? 16'd1 : 16'd0;
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.mem_regwrite = 1'b1; bus.mem_regwradd = 3'd5;
    bus.wb_regwrite = 1'b1;  bus.wb_regwradd = 3'd5;
    bus.ex_rs1 = 3'd5; bus.ex_rs2 = 3'd2;
    #1;
    checks++;
    if (bus.fwd_a !== 2'b01 || bus.fwd_b !== 2'b00) begin
      errors++; $display("FAIL fwd_mem got=%b/%b exp=01/00", bus.fwd_a, bus.fwd_b);
    end
    bus.mem_regwrite = 1'b0;
    #1;
    checks++;
    if (bus.fwd_a !== 2'b10) begin
      errors++; $display("FAIL fwd_wb got=%b exp=10", bus.fwd_a);
    end
    bus.wb_regwrite = 1'b0;
    bus.mem_regwrite = 1'b1; bus.mem_regwradd = 3'd0; bus.ex_rs2 = 3'd0;
    #1;
    checks++;
    if (bus.fwd_b !== 2'b01 || bus.fwd_a !== 2'b00) begin
      errors++; $display("FAIL fwd_r0 got=%b/%b exp=00/01", bus.fwd_a, bus.fwd_b);
    end
  endtask

  task automatic test_mem_wait();
    logic [15:0] exp_stall;
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctrl_vec() !== 6'b000000) begin
        errors++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctrl_vec(), 6'b000000);
      end
      step();
    end
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111100 || dut.state_q !== ST_MEM_WAIT) begin
      errors++; $display("FAIL mw_ack got=%b st=%0d exp=%b st=%0d", ctrl_vec(), dut.state_q, 6'b111100, ST_MEM_WAIT);
    end
    step();
    bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
    checks++;
    if (dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL mw_return got=%0d exp=%0d", dut.state_q, ST_RUN);
    end
    exp_stall = PERF ? 16'd3 : 16'd0;
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++; $display("FAIL mw_stall_cnt got=%0d exp=%0d", bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_ack_same_cycle();
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111100) begin
      errors++; $display("FAIL ack0_ctrl got=%b exp=%b", ctrl_vec(), 6'b111100);
    end
    step();
    checks++;
    if (dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL ack0_state got=%0d exp=%0d", dut.state_q, ST_RUN);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (dut.state_q !== ST_MEM_WAIT || bus.mem_err !== 1'b0) begin
      errors++; $display("FAIL to_before got=%0d err=%b exp=%0d err=0", dut.state_q, bus.mem_err, ST_MEM_WAIT);
    end
    step();
    checks++;
    if (dut.state_q !== ST_ERR || bus.mem_err !== 1'b1) begin
      errors++; $display("FAIL to_err got=%0d err=%b exp=%0d err=1", dut.state_q, bus.mem_err, ST_ERR);
    end
    bus.mem_req = 1'b0;
    bus.mem_regwrite = 1'b1; bus.mem_regwradd = 3'd6; bus.ex_rs1 = 3'd6;
    step(); step();
    checks++;
    if (bus.mem_err !== 1'b1 || ctrl_vec() !== 6'b000000) begin
      errors++; $display("FAIL to_sticky got err=%b ctrl=%b exp err=1 ctrl=000000", bus.mem_err, ctrl_vec());
    end
    checks++;
    if (bus.fwd_a !== 2'b01) begin
      errors++; $display("FAIL to_fwd got=%b exp=01", bus.fwd_a);
    end
    do_reset();
    checks++;
    if (dut.state_q !== ST_RUN || bus.mem_err !== 1'b0 || ctrl_vec() !== 6'b111100) begin
      errors++; $display("FAIL to_recover got st=%0d err=%b ctrl=%b exp RUN 0 111100", dut.state_q, bus.mem_err, ctrl_vec());
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp_flush;
    logic [15:0] exp_stall;
    do_reset();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_regwradd = 3'd2;
    bus.id_rs1 = 3'd2; bus.id_use_rs1 = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111111) begin
      errors++; $display("FAIL br_lu got=%b exp=%b", ctrl_vec(), 6'b111111);
    end
    step();
    exp_flush = PERF ? 16'd1 : 16'd0;
    checks++;
    if (bus.flush_count !== exp_flush || bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL br_cnt got=%0d/%0d exp=%0d/0", bus.flush_count, bus.stall_cycles, exp_flush);
    end
    bus.mem_req = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b000000) begin
      errors++; $display("FAIL br_frozen got=%b exp=%b", ctrl_vec(), 6'b000000);
    end
    step();
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 6'b111111) begin
      errors++; $display("FAIL br_release got=%b exp=%b", ctrl_vec(), 6'b111111);
    end
    step();
    exp_flush = PERF ? 16'd2 : 16'd0;
    exp_stall = PERF ? 16'd1 : 16'd0;
    checks++;
    if (bus.flush_count !== exp_flush || bus.stall_cycles !== exp_stall) begin
      errors++; $display("FAIL br_cnt2 got=%0d/%0d exp=%0d/%0d", bus.flush_count, bus.stall_cycles, exp_flush, exp_stall);
    end
  endtask

  task automatic test_rst_in_wait();
    do_reset();
    bus.mem_req = 1'b1;
    step(); step();
    checks++;
    if (dut.state_q !== ST_MEM_WAIT) begin
      errors++; $display("FAIL rw_wait got=%0d exp=%0d", dut.state_q, ST_MEM_WAIT);
    end
    rst = 1'b1;
    bus.wb_regwrite = 1'b1; bus.wb_regwradd = 3'd7; bus.ex_rs1 = 3'd7; bus.ex_rs2 = 3'd7;
    #1;
    checks++;
    if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00 || ctrl_vec() !== 6'b000011) begin
      errors++; $display("FAIL rw_forced got fwd=%b/%b ctrl=%b exp 00/00 000011", bus.fwd_a, bus.fwd_b, ctrl_vec());
    end
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (dut.state_q !== ST_RUN || dut.wait_q !== 8'd0) begin
      errors++; $display("FAIL rw_state got=%0d wait=%0d exp=RUN 0", dut.state_q, dut.wait_q);
    end
    checks++;
    if (bus.stall_cycles !== 16'd0 || bus.flush_count !== 16'd0) begin
      errors++; $display("FAIL rw_cnt got=%0d/%0d exp=0/0", bus.stall_cycles, bus.flush_count);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_wait();
    test_ack_same_cycle();
    test_timeout();
    test_branch();
    test_rst_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 8-bit, five-stage core with eight 3-bit-addressed registers. It generates the enables, flushes and bubbles for the IF/ID, ID/EX and EX/MEM pipeline registers. It also produces the EX-stage operand forwarding selects and freezes the pipeline while a data-memory access is waiting for acknowledge. A memory-timeout watchdog latches a fatal error state.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ack before the error state; 1..255.
- clk1  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  3 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the instruction in ID actually reads that source.
- ex_rs1, ex_rs2  in  3 each  source registers held in ID/EX.
- ex_regwradd  in  3  ID/EX destination register.
- ex_regwrite, ex_memread  in  1 each  ID/EX control bits.
- mem_regwradd  in  3  EX/MEM destination register.
- mem_regwrite  in  1  EX/MEM register-write control bit.
- wb_regwradd  in  3  MEM/WB destination register.
- wb_regwrite  in  1  MEM/WB register-write control bit.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- mem_req  in  1  EX/MEM holds a memory access (MemRead or MemWrite).
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush  out  1  loads a NOP into IF/ID.
- idex_bubble  out  1  clears ID/EX control bits.
- fwd_a, fwd_b  out  2 each  operand select: 00 = register file, 01 = EX/MEM alu_out, 10 = MEM/WB write data.
- mem_err  out  1  sticky timeout error.
- stall_cycles, flush_count  out  16 each  performance counters.

## Operation
- FSM states are RUN, MEM_WAIT and ERR. The state and the wait counter are registered. All other outputs are combinational from the state and the current inputs.
- Request priority, highest first: rst, ERR, freeze, branch, load-use, normal.
- Freeze condition: mem_req && !mem_ack, evaluated in RUN or MEM_WAIT.
  - Drives all four enables to 0, with ifid_flush=0 and idex_bubble=0.
  - RUN moves to MEM_WAIT and the wait counter is set to 1.
- MEM_WAIT:
  - The wait counter increments on each freeze cycle.
  - On mem_ack: the enables return to 1 in that same cycle, and the state returns to RUN on the next edge.
  - If the counter reaches MEM_TIMEOUT with no ack: the state moves to ERR.
- ERR:
  - All enables are 0 and mem_err=1.
  - Exited only by rst.
- Branch (branch_taken): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, exmem_en=1.
- Load-use hazard:
  - Detected when ex_memread && ex_regwrite && ((id_use_rs1 && id_rs1==ex_regwradd) || (id_use_rs2 && id_rs2==ex_regwradd)).
  - Response: pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1, exmem_en=1.
  - Lasts exactly one cycle: the load then sits in EX/MEM and is forwarded from WB.
- Normal: all enables 1, with ifid_flush=0 and idex_bubble=0.
- Forwarding for fwd_a (fwd_b is identical using ex_rs2):
  - 01 if mem_regwrite && mem_regwradd==ex_rs1;
  - else 10 if wb_regwrite && wb_regwradd==ex_rs1;
  - else 00.
  - All eight registers are real, so register 0 is not special-cased.
  - Forwarding is computed regardless of state.

## Timing
- Reset values, applied on the edge where rst=1:
  - state RUN, wait counter 0, mem_err 0, counters 0.
  - While rst is high the combinational outputs are forced to: enables 0, ifid_flush 1, idex_bubble 1, fwd 00.
- Hazard, flush and forward outputs have zero-cycle latency (same cycle as the inputs).
- A mem_ack arriving in the same cycle as the transition to MEM_WAIT wins: the state stays in RUN.
- A freeze during a branch or load-use cycle suppresses the flush and bubble; both are re-evaluated on the cycle the freeze releases.

## Configuration
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles counts freeze and load-use cycles.
  - flush_count counts branch flushes.
  - Both saturate at 16'hFFFF and are cleared by rst.
  - Counting stops in ERR.
- Undefined: both ports remain and are tied to 16'h0000, with no counter flops.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enumeration;
  - the fwd encodings (FWD_RF, FWD_MEM, FWD_WB);
  - the default MEM_TIMEOUT.
- Sub-module fwd_unit: purely combinational forwarding logic, instantiated once and producing both fwd_a and fwd_b.

## Test plan
- Load writes r3 in EX, ID instruction reads r3 via rs2 -> exactly one cycle of pc_en=0, ifid_en=0, idex_bubble=1; next cycle fwd_b=10.
- EX/MEM and MEM/WB both write r5, ex_rs1=5 -> fwd_a=01. Clear mem_regwrite -> fwd_a=10.
- mem_req=1, mem_ack arriving on the 4th cycle -> enables 0 for 3 cycles and 1 in the ack cycle; state RUN next edge; stall_cycles=3.
- mem_req held with no ack, MEM_TIMEOUT=15 -> ERR after 15 wait cycles, mem_err=1 held until rst; rst -> RUN, mem_err=0.
- branch_taken coincident with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_en=1; flush_count increments by 1.
- rst asserted during MEM_WAIT -> next cycle state RUN, counters 0, fwd 00.
